mcycle_alu_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer for the ARM core.
- Reuses the shared 32-bit ALU for one add or subtract per cycle. It does not contain its own adder.
- Performs unsigned 32x32->64 shift-add multiply (MUL/UMULL) and 32/32 restoring divide.
- Sits beside the Execute stage. The pipeline stalls on Busy while the sequencer owns the ALU.

---
 rtl/mcycle_alu_seq.sv | 165 ++++++++++++++++
 tb/tb_mcycle_alu_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mcycle_alu_seq.sv
// Multi-cycle unsigned multiply / restoring divide sequencer that borrows the shared ALU.
// Optional multiply early termination is enabled by defining MCYCLE_EARLY_TERM_EN.
module mcycle_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALU_SrcA,
  output logic [WIDTH-1:0] ALU_SrcB,
  output logic [2:0]       ALU_Control,
  output logic             ALU_Carry,
  output logic             ALU_CarryUsed,
  output logic             ALU_ReverseB,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic [3:0]       ALU_Flags
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             is_div;
  // hi/lo hold {product_hi, multiplier} for multiply and {R, Q} for divide
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] q_shift;
  logic             carry;
  logic             msb;
  logic             last_iter;
  logic             unused_flags;

`ifdef MCYCLE_EARLY_TERM_EN
  logic [WIDTH-1:0]   mrem;
  logic [CNT_W:0]     early_sh;
  logic [2*WIDTH-1:0] early_prod;
`endif

  assign carry        = ALU_Flags[1];
  assign unused_flags = ^{ALU_Flags[3:2], ALU_Flags[0]};
  assign msb          = hi[WIDTH-1];
  assign r_shift      = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign q_shift      = {lo[WIDTH-2:0], 1'b0};
  assign last_iter    = (count == CNT_W'(WIDTH - 1));

  assign ALU_Carry     = 1'b0;
  assign ALU_CarryUsed = 1'b0;
  assign ALU_ReverseB  = 1'b0;

`ifdef MCYCLE_EARLY_TERM_EN
  // Unconsumed multiplier bits are zero, so the partial product sits above them.
  assign early_sh   = (CNT_W+1)'(WIDTH) - {1'b0, count};
  assign early_prod = {hi, lo} >> early_sh;
`endif

  always_comb begin
    ALU_SrcA    = '0;
    ALU_SrcB    = '0;
    ALU_Control = ALU_ADD;
    hi_next     = hi;
    lo_next     = lo;
    if (state == COMPUTE) begin
      if (is_div) begin
        ALU_SrcA    = r_shift;
        ALU_SrcB    = opnd;
        ALU_Control = ALU_SUB;
        if (msb | carry) begin
          hi_next = ALU_Result;
          lo_next = {q_shift[WIDTH-1:1], 1'b1};
        end else begin
          hi_next = r_shift;
          lo_next = q_shift;
        end
      end else begin
        ALU_SrcA    = hi;
        ALU_SrcB    = lo[0] ? opnd : '0;
        ALU_Control = ALU_ADD;
        hi_next     = {carry, ALU_Result[WIDTH-1:1]};
        lo_next     = {ALU_Result[0], lo[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state   <= IDLE;
      count   <= '0;
      is_div  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      Result1 <= '0;
      Result2 <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
`ifdef MCYCLE_EARLY_TERM_EN
      mrem    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            is_div <= MCycleOp;
            count  <= '0;
            hi     <= '0;
            lo     <= MCycleOp ? Operand1 : Operand2;
            opnd   <= MCycleOp ? Operand2 : Operand1;
            Busy   <= 1'b1;
            state  <= COMPUTE;
`ifdef MCYCLE_EARLY_TERM_EN
            mrem   <= Operand2;
`endif
          end
        end
        COMPUTE: begin
`ifdef MCYCLE_EARLY_TERM_EN
          if (!is_div && mrem == '0) begin
            Result1 <= early_prod[WIDTH-1:0];
            Result2 <= early_prod[2*WIDTH-1:WIDTH];
            Done    <= 1'b1;
            state   <= DONE;
          end else begin
            mrem <= mrem >> 1;
`else
          begin
`endif
            hi    <= hi_next;
            lo    <= lo_next;
            count <= count + CNT_W'(1);
            if (last_iter) begin
              Result1 <= lo_next;
              Result2 <= hi_next;
              Done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_alu_seq.sv
// Directed vector bench for mcycle_alu_seq with a behavioural model of the shared ALU.
module tb_mcycle_alu_seq;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Start = 1'b0;
  logic        MCycleOp = 1'b0;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1, Result2;
  logic        Busy, Done;
  logic [31:0] ALU_SrcA, ALU_SrcB;
  logic [2:0]  ALU_Control;
  logic        ALU_Carry, ALU_CarryUsed, ALU_ReverseB;
  logic [31:0] ALU_Result;
  logic [3:0]  ALU_Flags;
  logic [32:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mcycle_alu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done),
    .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Control(ALU_Control),
    .ALU_Carry(ALU_Carry), .ALU_CarryUsed(ALU_CarryUsed), .ALU_ReverseB(ALU_ReverseB),
    .ALU_Result(ALU_Result), .ALU_Flags(ALU_Flags)
  );

  // ARM-style ALU: subtract sets C when there is no borrow
  always_comb begin
    if (ALU_Control == 3'b001) sum = {1'b0, ALU_SrcA} + {1'b0, ~ALU_SrcB} + 33'd1;
    else                       sum = {1'b0, ALU_SrcA} + {1'b0, ALU_SrcB};
  end
  assign ALU_Result = sum[31:0];
  assign ALU_Flags  = {sum[31], sum[31:0] == 32'd0, sum[32], 1'b0};

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int bitlen(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic int exp_done_cycle(input logic op, input logic [31:0] b);
`ifdef MCYCLE_EARLY_TERM_EN
    if (!op) return (bitlen(b) + 2 < 33) ? bitlen(b) + 2 : 33;
`endif
    if (op) return 33;
    return (bitlen(b) >= 0) ? 33 : 33;
  endfunction

  // Caller is positioned at a negedge with the DUT idle; returns at the negedge of cycle 1.
  task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // Walks cycles from 1 until Done, optionally pulsing a stray divide Start at cycle `inject`.
  task automatic wait_done(input int inject, output int done_cyc, output bit busy_ok);
    done_cyc = 0;
    busy_ok  = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge CLK);
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (Done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (c == inject) begin
        Start = 1'b1; MCycleOp = 1'b1; Operand1 = 32'd100; Operand2 = 32'd7;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
  endtask

  int  done_cyc;
  bit  busy_ok;
  bit  saw_done;

  initial begin
    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    vecs[1]  = '{1'b0, 32'd7,        32'd6,        32'h0000002A, 32'h00000000};
    vecs[2]  = '{1'b0, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000};
    vecs[3]  = '{1'b0, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000};
    vecs[4]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001};
    vecs[5]  = '{1'b0, 32'h80000000, 32'd2,        32'h00000000, 32'h00000001};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h00000001};
    vecs[7]  = '{1'b0, 32'h12345678, 32'd1,        32'h12345678, 32'h00000000};
    vecs[8]  = '{1'b1, 32'd100,      32'd7,        32'd14,       32'd2};
    vecs[9]  = '{1'b1, 32'h80000000, 32'd3,        32'h2AAAAAAA, 32'd2};
    vecs[10] = '{1'b1, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678};
    vecs[11] = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
    vecs[12] = '{1'b1, 32'd5,        32'd10,       32'd0,        32'd5};
    vecs[13] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[14] = '{1'b1, 32'hFFFFFFFF, 32'h80000000, 32'd1,        32'h7FFFFFFF};
    vecs[15] = '{1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE};

    repeat (3) @(negedge CLK);
    check("reset_busy_done", {62'd0, Busy, Done}, 64'd0);
    check("reset_results", {Result2, Result1}, 64'd0);
    check("reset_alu", {ALU_SrcA, ALU_SrcB}, 64'd0);
    check("alu_tieoffs", {58'd0, ALU_Control, ALU_Carry, ALU_CarryUsed, ALU_ReverseB}, 64'd0);
    RESETn = 1'b1;
    @(negedge CLK);

    // Each vector starts in the cycle right after the previous Done, so these run back-to-back.
    for (int i = 0; i < 16; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, done_cyc, busy_ok);
      check($sformatf("v%0d_done_cycle", i), 64'(done_cyc), 64'(exp_done_cycle(vecs[i].op, vecs[i].b)));
      check($sformatf("v%0d_busy_span", i), {63'd0, busy_ok}, 64'd1);
      check($sformatf("v%0d_result1", i), {32'd0, Result1}, {32'd0, vecs[i].r1});
      check($sformatf("v%0d_result2", i), {32'd0, Result2}, {32'd0, vecs[i].r2});
      @(negedge CLK);
      check($sformatf("v%0d_after_done", i), {62'd0, Busy, Done}, 64'd0);
      check($sformatf("v%0d_idle_alu", i), {ALU_SrcA, ALU_SrcB}, 64'd0);
      check($sformatf("v%0d_idle_ctl", i), {61'd0, ALU_Control}, 64'd0);
    end

    // Stray Start during a busy multiply must not disturb the operation.
    @(negedge CLK);
    start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(10, done_cyc, busy_ok);
    check("ignore_done_cycle", 64'(done_cyc), 64'(exp_done_cycle(1'b0, 32'hFFFFFFFF)));
    check("ignore_result", {Result2, Result1}, 64'hFFFFFFFE_00000001);
    check("ignore_busy_span", {63'd0, busy_ok}, 64'd1);
    @(negedge CLK);
    check("ignore_no_restart", {62'd0, Busy, Done}, 64'd0);

    // Reset in cycle 15 of a divide aborts it with no Done pulse.
    @(negedge CLK);
    start_op(1'b1, 32'h80000000, 32'd3);
    repeat (14) @(negedge CLK);
    check("pre_reset_busy", {63'd0, Busy}, 64'd1);
    RESETn = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    check("abort_busy_done", {62'd0, Busy, Done}, 64'd0);
    check("abort_results", {Result2, Result1}, 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (Done === 1'b1 || Busy === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);

    // A fresh operation still works after the aborted one.
    start_op(1'b1, 32'd100, 32'd7);
    wait_done(0, done_cyc, busy_ok);
    check("post_abort_result", {Result2, Result1}, {32'd2, 32'd14});
    check("post_abort_done_cycle", 64'(done_cyc), 64'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
